etc_semiring_mma: RTL

//  Next-gen Extended Tensor Core tile unit: NxN (A (x) B) over a selectable semiring, with K-tile accumulation.

---
 rtl/etc_semiring_mma.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/etc_semiring_mma.sv
// NxN tile multiply over a selectable semiring with first/last-framed K-tile accumulation.
// Define ETC_SEMIRING_SAT_EN to make every + and * saturate at 2^W-1 instead of wrapping.
module etc_semiring_mma #(
  parameter int unsigned W = 16,
  parameter int unsigned N = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [1:0]                   op,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_first,
  input  logic                         in_last,
  input  logic [N-1:0][N-1:0][W-1:0]   inA,
  input  logic [N-1:0][N-1:0][W-1:0]   inB,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [N-1:0][N-1:0][W-1:0]   out
);

  localparam int unsigned W2 = 2 * W;

  typedef logic [N-1:0][N-1:0][W-1:0] tile_t;

  function automatic logic [W-1:0] f_add(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef ETC_SEMIRING_SAT_EN
    logic [W:0] s;
    s = (W+1)'(a) + (W+1)'(b);
    return s[W] ? {W{1'b1}} : s[W-1:0];
`else
    return a + b;
`endif
  endfunction

  function automatic logic [W-1:0] f_mul(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef ETC_SEMIRING_SAT_EN
    logic [W2-1:0] p;
    p = W2'(a) * W2'(b);
    return (|p[W2-1:W]) ? {W{1'b1}} : p[W-1:0];
`else
    return a * b;
`endif
  endfunction

  function automatic logic [W-1:0] f_min(input logic [W-1:0] a, input logic [W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [W-1:0] f_max(input logic [W-1:0] a, input logic [W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  // Semiring multiply (x)
  function automatic logic [W-1:0] f_otimes(input logic [1:0] o, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
    case (o)
      2'd0:    return f_mul(a, b);
      2'd1:    return f_add(a, b);
      2'd2:    return f_add(a, b);
      default: return f_min(a, b);
    endcase
  endfunction

  // Semiring reduce R
  function automatic logic [W-1:0] f_reduce(input logic [1:0] o, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
    case (o)
      2'd0:    return f_add(a, b);
      2'd1:    return f_min(a, b);
      default: return f_max(a, b);
    endcase
  endfunction

  logic        s1_valid;
  logic        s1_first;
  logic        s1_last;
  tile_t       s1_a;
  tile_t       s1_b;
  logic [1:0]  grp_op;
  logic        in_grp;
  logic        grp_open;
  tile_t       acc;
  tile_t       prod;
  tile_t       comb_val;
  logic        accept;
  logic        advance;
  logic        open_beat;

  assign advance   = s1_valid & (!s1_last | !out_valid | out_ready);
  assign in_ready  = !s1_valid | advance;
  assign accept    = in_valid & in_ready;
  assign open_beat = s1_first | !grp_open;

  // Tile product for the stage-1 beat, then fold into the running accumulator
  always_comb begin
    prod     = '0;
    comb_val = '0;
    for (int i = 0; i < int'(N); i++) begin
      for (int j = 0; j < int'(N); j++) begin
        prod[i][j] = f_otimes(grp_op, s1_a[i][0], s1_b[0][j]);
        for (int k = 1; k < int'(N); k++) begin
          prod[i][j] = f_reduce(grp_op, prod[i][j], f_otimes(grp_op, s1_a[i][k], s1_b[k][j]));
        end
        comb_val[i][j] = open_beat ? prod[i][j] : f_reduce(grp_op, acc[i][j], prod[i][j]);
      end
    end
  end

  // in_grp tracks group framing on the accept side so op is latched only on opening beats
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_first  <= 1'b0;
      s1_last   <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      grp_op    <= 2'd0;
      in_grp    <= 1'b0;
      grp_open  <= 1'b0;
      acc       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
        s1_first <= in_first;
        s1_last  <= in_last;
        s1_a     <= inA;
        s1_b     <= inB;
        in_grp   <= !in_last;
        if (in_first | !in_grp) grp_op <= op;
      end else if (advance) begin
        s1_valid <= 1'b0;
      end

      if (out_valid & out_ready) out_valid <= 1'b0;

      if (advance) begin
        acc <= comb_val;
        if (s1_last) begin
          out       <= comb_val;
          out_valid <= 1'b1;
          grp_open  <= 1'b0;
        end else begin
          grp_open  <= 1'b1;
        end
      end
    end
  end

endmodule
